io_bridge: RTL and testbench

- Memory-mapped I/O slave on the CPU byte bus (address, data-out, write strobe). It sits directly downstream of the CPU core, beside the 128KB RAM.
- Decodes accesses with addr[17:16]==2'b11 and implements the UART input/output, cycle-counter and program-stop registers.
- Buffers UART traffic in RX and TX FIFOs.
- Generates the CPU ready signal, holding the core when an I/O access cannot complete.

---
 rtl/io_bridge.sv | 171 +++++++++++++++++
 tb/tb_io_bridge.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bridge.sv
// Memory-mapped I/O slave beside the CPU RAM: UART RX/TX FIFOs, a free-running
// cycle counter with a coherent snapshot, a sticky program-stop flag and CPU ready.

module io_bridge_fifo #(
    parameter int unsigned AW = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       full,
    output logic       empty
);
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned PW    = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    // Extra pointer MSB separates full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
    end
endmodule

module io_bridge #(
    parameter int unsigned RX_AW = 4,
    parameter int unsigned TX_AW = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [17:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  io_dout,
    output logic        io_rd_q,
    output logic        io_rdy,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        program_finish
);
    localparam int unsigned CNT_W = 32;

    logic             io_sel;
    logic [2:0]       reg_a;
    logic             sel_data;
    logic             sel_stop;
    logic             rx_rd_req;
    logic             tx_wr_req;
    logic             rd_acc;
    logic             wr_acc;
    logic             rx_push;
    logic             rx_pop;
    logic [7:0]       rx_head;
    logic             rx_full;
    logic             rx_empty;
    logic             tx_push;
    logic [7:0]       tx_wdata;
    logic             tx_pop;
    logic [7:0]       tx_head;
    logic             tx_full;
    logic             tx_empty;
    logic [7:0]       rd_data;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] snapshot;
    logic             unused_addr;

    // Only the I/O window bits and the register offset take part in decode.
    assign unused_addr = ^cpu_a[15:3];

    assign io_sel   = (cpu_a[17:16] == 2'b11);
    assign reg_a    = cpu_a[2:0];
    assign sel_data = (reg_a == 3'd0);
    assign sel_stop = (reg_a == 3'd4);

    assign rx_rd_req = io_sel && !cpu_wr && sel_data;
    assign tx_wr_req = io_sel && cpu_wr && ((sel_data && (cpu_dout != 8'h00)) || sel_stop);

    // Full/empty are taken before this cycle's pop/push, so they win over a same-cycle drain/fill.
    assign io_rdy = !((rx_rd_req && rx_empty) || (tx_wr_req && tx_full));

    assign rd_acc = io_sel && !cpu_wr && io_rdy;
    assign wr_acc = io_sel && cpu_wr && io_rdy;

    assign rx_ready = !rx_full;
    assign rx_push  = rx_valid && !rx_full;
    assign rx_pop   = rd_acc && sel_data;

    assign tx_push  = wr_acc && !program_finish
                      && ((sel_data && (cpu_dout != 8'h00)) || sel_stop);
    assign tx_wdata = sel_stop ? 8'h00 : cpu_dout;
    assign tx_valid = !tx_empty;
    assign tx_data  = tx_empty ? 8'h00 : tx_head;
    assign tx_pop   = tx_valid && tx_ready;

    io_bridge_fifo #(.AW(RX_AW)) u_rx_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .push  (rx_push),
        .wdata (rx_data),
        .pop   (rx_pop),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    io_bridge_fifo #(.AW(TX_AW)) u_tx_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .push  (tx_push),
        .wdata (tx_wdata),
        .pop   (tx_pop),
        .rdata (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // Byte 0 of the counter is live; upper bytes come from the snapshot it latches.
    always_comb begin
        rd_data = 8'h00;
        case (reg_a)
            3'd0:    rd_data = rx_head;
            3'd4:    rd_data = counter[7:0];
            3'd5:    rd_data = snapshot[15:8];
            3'd6:    rd_data = snapshot[23:16];
            3'd7:    rd_data = snapshot[31:24];
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            io_dout        <= 8'h00;
            io_rd_q        <= 1'b0;
            counter        <= '0;
            snapshot       <= '0;
            program_finish <= 1'b0;
        end else begin
            io_rd_q <= rd_acc;
            if (rd_acc) io_dout <= rd_data;
            if (rd_acc && sel_stop) snapshot <= counter;
            if (!program_finish) counter <= counter + CNT_W'(1);
            if (wr_acc && sel_stop) program_finish <= 1'b1;
        end
    end
endmodule

// File: tb/tb_io_bridge.sv
// Scoreboard bench for io_bridge: expected TX bytes and read data are queued as
// stimulus is driven and compared when the bridge produces them.

module tb_io_bridge;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [17:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  io_dout;
    logic        io_rd_q;
    logic        io_rdy;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        program_finish;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  tx_exp [$];
    logic [7:0]  rd_exp [$];
    logic [7:0]  tx_log [256];
    int          tx_n = 0;
    int          tx_rd = 0;
    logic [7:0]  exp_b;
    int          st;
    logic [7:0]  wr_bytes [3] = '{8'h48, 8'h00, 8'h69};

    io_bridge #(.RX_AW(4), .TX_AW(4)) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .cpu_a          (cpu_a),
        .cpu_dout       (cpu_dout),
        .cpu_wr         (cpu_wr),
        .io_dout        (io_dout),
        .io_rd_q        (io_rd_q),
        .io_rdy         (io_rdy),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .program_finish (program_finish)
    );

    always #5 clk_in = ~clk_in;

    // Record every byte the transmitter takes, sampled mid-cycle.
    always @(negedge clk_in) begin
        if (!rst_in && tx_valid && tx_ready) begin
            tx_log[tx_n[7:0]] <= tx_data;
            tx_n <= tx_n + 1;
        end
    end

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic bus_idle;
        cpu_a    = 18'h0;
        cpu_wr   = 1'b0;
        cpu_dout = 8'h00;
    endtask

    task automatic do_reset;
        bus_idle();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
    endtask

    // Present one access and hold it until accepted; returns the stall count.
    task automatic cpu_access(input logic [17:0] a, input logic wr, input logic [7:0] d,
                              output int stalls);
        cpu_a = a; cpu_wr = wr; cpu_dout = d; stalls = 0;
        #1;
        while (!io_rdy && stalls < 100) begin
            tick();
            stalls++;
        end
        if (!io_rdy) begin
            n_cmp++; n_err++;
            $display("FAIL access_timeout addr=%h io_rdy=%b want 1", a, io_rdy);
        end
        tick();
        bus_idle();
    endtask

    task automatic wait_tx(input int target);
        int k = 0;
        while (tx_n < target && k < 200) begin
            tick();
            k++;
        end
        if (tx_n < target) begin
            n_cmp++; n_err++;
            $display("FAIL tx_timeout got %0d bytes want %0d", tx_n, target);
        end
    endtask

    task automatic test_reset;
        rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
        do_reset();
        n_cmp++; if (io_dout !== 8'h00) begin n_err++; $display("FAIL reset_io_dout got %h want 00", io_dout); end
        n_cmp++; if (io_rd_q !== 1'b0) begin n_err++; $display("FAIL reset_io_rd_q got %b want 0", io_rd_q); end
        n_cmp++; if (io_rdy !== 1'b1) begin n_err++; $display("FAIL reset_io_rdy got %b want 1", io_rdy); end
        n_cmp++; if (rx_ready !== 1'b1) begin n_err++; $display("FAIL reset_rx_ready got %b want 1", rx_ready); end
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
        n_cmp++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
        n_cmp++; if (program_finish !== 1'b0) begin n_err++; $display("FAIL reset_finish got %b want 0", program_finish); end
    endtask

    task automatic test_rx_read;
        do_reset();
        cpu_a = 18'h30000; cpu_wr = 1'b0;
        #1;
        n_cmp++; if (io_rdy !== 1'b0) begin n_err++; $display("FAIL rx_empty_stall got %b want 0", io_rdy); end
        tick();
        n_cmp++; if (io_rdy !== 1'b0) begin n_err++; $display("FAIL rx_stall_held got %b want 0", io_rdy); end
        rx_data = 8'h41; rx_valid = 1'b1; rd_exp.push_back(8'h41);
        tick();
        rx_valid = 1'b0;
        #1;
        n_cmp++; if (io_rdy !== 1'b1) begin n_err++; $display("FAIL rx_stall_release got %b want 1", io_rdy); end
        tick();
        bus_idle();
        exp_b = rd_exp.pop_front();
        n_cmp++; if (io_rd_q !== 1'b1) begin n_err++; $display("FAIL rx_rd_q got %b want 1", io_rd_q); end
        n_cmp++; if (io_dout !== exp_b) begin n_err++; $display("FAIL rx_data got %h want %h", io_dout, exp_b); end
        cpu_a = 18'h30000;
        #1;
        n_cmp++; if (io_rdy !== 1'b0) begin n_err++; $display("FAIL rx_empty_after_pop got %b want 0", io_rdy); end
        cpu_a = 18'h10000;
        tick();
        bus_idle();
        n_cmp++; if (io_rd_q !== 1'b0) begin n_err++; $display("FAIL ram_rd_q got %b want 0", io_rd_q); end
    endtask

    task automatic test_tx_write;
        tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cpu_access(18'h30000, 1'b1, wr_bytes[i], st);
            if (wr_bytes[i] != 8'h00) tx_exp.push_back(wr_bytes[i]);
        end
        wait_tx(tx_rd + tx_exp.size());
        repeat (4) tick();
        while (tx_exp.size() > 0) begin
            exp_b = tx_exp.pop_front();
            n_cmp++;
            if (tx_rd >= tx_n || tx_log[tx_rd[7:0]] !== exp_b) begin
                n_err++; $display("FAIL tx_stream[%0d] got %h want %h", tx_rd, tx_log[tx_rd[7:0]], exp_b);
            end
            tx_rd++;
        end
        n_cmp++; if (tx_n !== tx_rd) begin n_err++; $display("FAIL tx_no_zero got %0d bytes want %0d", tx_n, tx_rd); end
    endtask

    task automatic test_tx_full;
        int stall_sum = 0;
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cpu_access(18'h30000, 1'b1, 8'(8'h10 + i), st);
            stall_sum += st;
            tx_exp.push_back(8'(8'h10 + i));
        end
        n_cmp++; if (stall_sum !== 0) begin n_err++; $display("FAIL tx_fill_stalls got %0d want 0", stall_sum); end
        cpu_a = 18'h30000; cpu_wr = 1'b1; cpu_dout = 8'h20;
        #1;
        n_cmp++; if (io_rdy !== 1'b0) begin n_err++; $display("FAIL tx_full_stall got %b want 0", io_rdy); end
        tick();
        n_cmp++; if (io_rdy !== 1'b0) begin n_err++; $display("FAIL tx_full_held got %b want 0", io_rdy); end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        #1;
        n_cmp++; if (io_rdy !== 1'b1) begin n_err++; $display("FAIL tx_full_release got %b want 1", io_rdy); end
        tx_exp.push_back(8'h20);
        tick();
        bus_idle();
        tx_ready = 1'b1;
        wait_tx(tx_rd + tx_exp.size());
        repeat (4) tick();
        while (tx_exp.size() > 0) begin
            exp_b = tx_exp.pop_front();
            n_cmp++;
            if (tx_rd >= tx_n || tx_log[tx_rd[7:0]] !== exp_b) begin
                n_err++; $display("FAIL tx_order[%0d] got %h want %h", tx_rd, tx_log[tx_rd[7:0]], exp_b);
            end
            tx_rd++;
        end
        n_cmp++; if (tx_n !== tx_rd) begin n_err++; $display("FAIL tx_full_count got %0d want %0d", tx_n, tx_rd); end
    endtask

    task automatic test_counter;
        do_reset();
        repeat (511) tick();
        rd_exp.push_back(8'hFF);
        cpu_a = 18'h30004; cpu_wr = 1'b0;
        tick();
        bus_idle();
        exp_b = rd_exp.pop_front();
        n_cmp++; if (io_rd_q !== 1'b1) begin n_err++; $display("FAIL cnt_rd_q got %b want 1", io_rd_q); end
        n_cmp++; if (io_dout !== exp_b) begin n_err++; $display("FAIL cnt_byte0 got %h want %h", io_dout, exp_b); end
        repeat (5) tick();
        rd_exp.push_back(8'h01); rd_exp.push_back(8'h00); rd_exp.push_back(8'h00);
        for (int k = 1; k < 4; k++) begin
            cpu_access(18'(18'h30004 + k), 1'b0, 8'h00, st);
            exp_b = rd_exp.pop_front();
            n_cmp++; if (io_dout !== exp_b) begin n_err++; $display("FAIL cnt_byte%0d got %h want %h", k, io_dout, exp_b); end
        end
        rd_exp.push_back(8'h00);
        cpu_access(18'h30001, 1'b0, 8'h00, st);
        exp_b = rd_exp.pop_front();
        n_cmp++; if (io_dout !== exp_b) begin n_err++; $display("FAIL other_reg got %h want %h", io_dout, exp_b); end
    endtask

    task automatic test_stop;
        do_reset();
        tx_ready = 1'b1;
        cpu_access(18'h30004, 1'b1, 8'hAA, st);
        tx_exp.push_back(8'h00);
        n_cmp++; if (program_finish !== 1'b1) begin n_err++; $display("FAIL stop_finish got %b want 1", program_finish); end
        wait_tx(tx_rd + tx_exp.size());
        exp_b = tx_exp.pop_front();
        n_cmp++;
        if (tx_log[tx_rd[7:0]] !== exp_b) begin n_err++; $display("FAIL stop_tx got %h want %h", tx_log[tx_rd[7:0]], exp_b); end
        tx_rd++;
        repeat (20) tick();
        rd_exp.push_back(8'h01); rd_exp.push_back(8'h00);
        cpu_access(18'h30004, 1'b0, 8'h00, st);
        exp_b = rd_exp.pop_front();
        n_cmp++; if (io_dout !== exp_b) begin n_err++; $display("FAIL frozen_byte0 got %h want %h", io_dout, exp_b); end
        cpu_access(18'h30005, 1'b0, 8'h00, st);
        exp_b = rd_exp.pop_front();
        n_cmp++; if (io_dout !== exp_b) begin n_err++; $display("FAIL frozen_byte1 got %h want %h", io_dout, exp_b); end
        cpu_access(18'h30000, 1'b1, 8'h55, st);
        cpu_access(18'h30004, 1'b1, 8'h00, st);
        repeat (6) tick();
        n_cmp++; if (tx_n !== tx_rd) begin n_err++; $display("FAIL tx_after_stop got %0d bytes want %0d", tx_n, tx_rd); end
        n_cmp++; if (program_finish !== 1'b1) begin n_err++; $display("FAIL stop_sticky got %b want 1", program_finish); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 15; i++) cpu_access(18'h30000, 1'b1, 8'(8'h80 + i), st);
        for (int i = 0; i < 3; i++) begin
            rx_data = 8'(8'hC0 + i); rx_valid = 1'b1;
            tick();
        end
        rx_valid = 1'b0;
        cpu_access(18'h30004, 1'b1, 8'h00, st);
        cpu_a = 18'h30004; cpu_wr = 1'b1;
        #1;
        n_cmp++; if (io_rdy !== 1'b0) begin n_err++; $display("FAIL mid_stall got %b want 0", io_rdy); end
        tick();
        do_reset();
        n_cmp++; if (io_rdy !== 1'b1) begin n_err++; $display("FAIL mid_rst_rdy got %b want 1", io_rdy); end
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_tx_valid got %b want 0", tx_valid); end
        n_cmp++; if (program_finish !== 1'b0) begin n_err++; $display("FAIL mid_rst_finish got %b want 0", program_finish); end
        rd_exp.push_back(8'h00);
        cpu_a = 18'h30004; cpu_wr = 1'b0;
        tick();
        bus_idle();
        exp_b = rd_exp.pop_front();
        n_cmp++; if (io_rd_q !== 1'b1 || io_dout !== exp_b) begin
            n_err++; $display("FAIL mid_rst_counter got rd_q=%b %h want rd_q=1 %h", io_rd_q, io_dout, exp_b);
        end
        cpu_a = 18'h30000;
        #1;
        n_cmp++; if (io_rdy !== 1'b0) begin n_err++; $display("FAIL mid_rst_rx_empty got %b want 0", io_rdy); end
        bus_idle();
        tx_ready = 1'b1;
        repeat (6) tick();
        n_cmp++; if (tx_n !== tx_rd) begin n_err++; $display("FAIL mid_rst_tx_empty got %0d bytes want %0d", tx_n, tx_rd); end
    endtask

    initial begin
        rst_in = 1'b1;
        bus_idle();
        rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
        repeat (2) tick();
        test_reset();
        test_rx_read();
        test_tx_write();
        test_tx_full();
        test_counter();
        test_stop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end
endmodule
